// File: rtl/simon_pkg.sv
// Shared definitions for the Simon game blocks: colour codes, player
// state encoding, sizing constants and the colour-to-LED decode.
package simon_pkg;

   localparam int SEQ_MAX_LEN = 32;
   localparam int DELAY_IDX_W = 5;

   localparam logic [1:0] COL_RED    = 2'd0;
   localparam logic [1:0] COL_GREEN  = 2'd1;
   localparam logic [1:0] COL_BLUE   = 2'd2;
   localparam logic [1:0] COL_YELLOW = 2'd3;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE      = 3'd0;
   localparam state_t ST_FETCH     = 3'd1;
   localparam state_t ST_WAIT_DATA = 3'd2;
   localparam state_t ST_ON        = 3'd3;
   localparam state_t ST_GAP       = 3'd4;
   localparam state_t ST_DONE      = 3'd5;

   function automatic logic [3:0] onehot4(input logic [1:0] color);
      return 4'b0001 << color;
   endfunction

endpackage

// File: rtl/simon_sequence_player.sv
// Plays the stored colour sequence on the LEDs. Each step lights one LED
// for one timer period, then darkens it for one timer period. The timer
// is restarted on entry to every ON and GAP phase, and its expiry pulse
// is honoured only once the restart cycle has passed.
module simon_sequence_player
   import simon_pkg::*;
#(
   parameter int MAX_LEN = SEQ_MAX_LEN,
   parameter int ADDR_W  = 5,
   parameter int COLOR_W = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic                   abort,
   input  logic [5:0]             seq_len,
   output logic [ADDR_W-1:0]      seq_rd_addr,
   input  logic [COLOR_W-1:0]     seq_rd_data,
   output logic [3:0]             led,
   output logic                   delay_restart,
   output logic [DELAY_IDX_W-1:0] delay_index,
   input  logic                   delay_pulse,
   output logic                   busy,
   output logic                   done
);

   state_t                 state_q, state_d;
   logic [5:0]             step_q, step_d;
   logic [5:0]             len_q, len_d;
   logic [DELAY_IDX_W-1:0] idx_q, idx_d;
   logic                   first_q, first_d;
   logic [COLOR_W-1:0]     colour_q, colour_d;

   logic [5:0] len_clip;
   logic [5:0] len_m1;
   logic [5:0] step_inc;

   // Clamp the requested length to the RAM depth; speed index follows it.
   always_comb begin
      len_clip = (seq_len > 6'(MAX_LEN)) ? 6'(MAX_LEN) : seq_len;
      len_m1   = len_clip - 6'd1;
      step_inc = step_q + 6'd1;
   end

   // Next-state logic; first_d marks the timer-restart cycle of ON/GAP.
   always_comb begin
      state_d  = state_q;
      step_d   = step_q;
      len_d    = len_q;
      idx_d    = idx_q;
      first_d  = 1'b0;
      colour_d = colour_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (seq_len == 6'd0) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_FETCH;
                  len_d   = len_clip;
                  step_d  = 6'd0;
                  idx_d   = (len_m1 > 6'd31) ? 5'd31 : len_m1[DELAY_IDX_W-1:0];
               end
            end
         end
         ST_FETCH: state_d = ST_WAIT_DATA;
         ST_WAIT_DATA: begin
            colour_d = seq_rd_data;
            state_d  = ST_ON;
            first_d  = 1'b1;
         end
         ST_ON: begin
            if (!first_q && delay_pulse) begin
               state_d = ST_GAP;
               first_d = 1'b1;
            end
         end
         ST_GAP: begin
            if (!first_q && delay_pulse) begin
               step_d  = step_inc;
               state_d = (step_inc == len_q) ? ST_DONE : ST_FETCH;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      // Abort overrides any pulse or start seen in the same cycle.
      if (abort && (state_q != ST_IDLE)) begin
         state_d = ST_IDLE;
         step_d  = 6'd0;
         first_d = 1'b0;
      end
   end

   // Control registers, cleared by the synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         step_q  <= 6'd0;
         len_q   <= 6'd0;
         idx_q   <= '0;
         first_q <= 1'b0;
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
         len_q   <= len_d;
         idx_q   <= idx_d;
         first_q <= first_d;
      end
   end

   // Colour holding register; only observed while in ON, so never reset.
   always_ff @(posedge clk) begin
      colour_q <= colour_d;
   end

   // Outputs decoded from registered state only.
   always_comb begin
      busy          = (state_q != ST_IDLE);
      done          = (state_q == ST_DONE);
      led           = (state_q == ST_ON) ? onehot4(colour_q) : 4'b0000;
      delay_restart = !(((state_q == ST_ON) || (state_q == ST_GAP)) && !first_q);
      seq_rd_addr   = step_q[ADDR_W-1:0];
      delay_index   = idx_q;
   end

endmodule

// File: tb/tb_simon_sequence_player.sv
// Bench for simon_sequence_player: a registered sequence RAM, a delay timer
// model with a programmable pulse delay, and an expected per-cycle output
// trace built from the playback timing rules.
module tb_simon_sequence_player;
   import simon_pkg::*;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic [5:0] seq_len = 6'd0;
   logic [4:0] seq_rd_addr;
   logic [1:0] seq_rd_data;
   logic [3:0] led;
   logic       delay_restart;
   logic [4:0] delay_index;
   logic       delay_pulse;
   logic       busy;
   logic       done;

   logic [1:0] mem [32];
   int         tmr_t = 10;
   int         tcnt = 0;
   logic       inj = 1'b0;
   logic       tmr_pulse;

   int n_total = 0;
   int n_pass  = 0;
   int cur_idx = 0;

   typedef struct {
      logic [3:0] led;
      int         addr;
      logic       rst;
      logic       busy;
      logic       done;
   } exp_t;

   always #5 clk = ~clk;

   simon_sequence_player dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort), .seq_len(seq_len),
      .seq_rd_addr(seq_rd_addr), .seq_rd_data(seq_rd_data), .led(led),
      .delay_restart(delay_restart), .delay_index(delay_index),
      .delay_pulse(delay_pulse), .busy(busy), .done(done)
   );

   // Sequence RAM: data appears one cycle after the address.
   always @(posedge clk) seq_rd_data <= mem[seq_rd_addr];

   // Delay timer: pulses on the tmr_t-th cycle after restart is released.
   always @(posedge clk) begin
      if (delay_restart) tcnt <= 0;
      else if (tcnt < 1000) tcnt <= tcnt + 1;
   end
   assign tmr_pulse   = !delay_restart && (tcnt == tmr_t - 1);
   assign delay_pulse = tmr_pulse | inj;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_total++;
      assert (obs === expv) begin
         n_pass++;
      end else begin
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic chk_idle(input string tag, input int idx);
      chk({tag, ".led"}, 32'(led), 32'd0);
      chk({tag, ".restart"}, 32'(delay_restart), 32'd1);
      chk({tag, ".busy"}, 32'(busy), 32'd0);
      chk({tag, ".done"}, 32'(done), 32'd0);
      chk({tag, ".idx"}, 32'(delay_index), 32'(idx));
   endtask

   function automatic exp_t mk(logic [3:0] l, int a, logic r, logic b, logic d);
      exp_t e;
      e.led = l; e.addr = a; e.rst = r; e.busy = b; e.done = d;
      return e;
   endfunction

   // One playback: builds the expected trace, then walks it cycle by cycle.
   // abort_at / reset_at / busy_start_at are trace cycle numbers, -1 = none.
   task automatic run(input string tag, input int len_in, input int t,
                      input int abort_at, input int reset_at,
                      input bit do_inj, input int busy_start_at);
      exp_t q[$];
      int   len;
      int   new_idx;
      logic [3:0] oh;
      len = (len_in > 32) ? 32 : len_in;
      tmr_t = t;
      q.push_back(mk(4'b0, -1, 1'b1, 1'b0, 1'b0));
      for (int s = 0; s < len; s++) begin
         oh = 4'b0001 << mem[s];
         q.push_back(mk(4'b0, s, 1'b1, 1'b1, 1'b0));
         q.push_back(mk(4'b0, s, 1'b1, 1'b1, 1'b0));
         q.push_back(mk(oh, -1, 1'b1, 1'b1, 1'b0));
         for (int i = 0; i < t; i++) q.push_back(mk(oh, -1, 1'b0, 1'b1, 1'b0));
         q.push_back(mk(4'b0, -1, 1'b1, 1'b1, 1'b0));
         for (int i = 0; i < t; i++) q.push_back(mk(4'b0, -1, 1'b0, 1'b1, 1'b0));
      end
      q.push_back(mk(4'b0, -1, 1'b1, 1'b1, 1'b1));
      q.push_back(mk(4'b0, -1, 1'b1, 1'b0, 1'b0));
      q.push_back(mk(4'b0, -1, 1'b1, 1'b0, 1'b0));
      new_idx = (len > 0) ? len - 1 : cur_idx;

      for (int k = 0; k < q.size(); k++) begin
         chk($sformatf("%s.c%0d.led", tag, k), 32'(led), 32'(q[k].led));
         chk($sformatf("%s.c%0d.restart", tag, k), 32'(delay_restart), 32'(q[k].rst));
         chk($sformatf("%s.c%0d.busy", tag, k), 32'(busy), 32'(q[k].busy));
         chk($sformatf("%s.c%0d.done", tag, k), 32'(done), 32'(q[k].done));
         if (q[k].addr >= 0)
            chk($sformatf("%s.c%0d.addr", tag, k), 32'(seq_rd_addr), 32'(q[k].addr));
         chk($sformatf("%s.c%0d.idx", tag, k), 32'(delay_index),
             32'((k == 0) ? cur_idx : new_idx));

         start   = (k == 0) || (k == busy_start_at);
         seq_len = (k == 0) ? 6'(len_in) :
                   (k == busy_start_at) ? 6'($urandom_range(1, 63)) : seq_len;
         abort   = (k == abort_at);
         reset   = (k == reset_at);
         inj     = do_inj && (len > 0) && (k == 1 || k == 2 || k == 3 || k == 4 + t);
         @(posedge clk);
         #1;
         start = 1'b0;
         abort = 1'b0;
         reset = 1'b0;
         inj   = 1'b0;
         if (k == abort_at) begin
            chk_idle({tag, ".after_abort"}, new_idx);
            cur_idx = new_idx;
            return;
         end
         if (k == reset_at) begin
            chk_idle({tag, ".after_reset"}, 0);
            chk({tag, ".after_reset.addr"}, 32'(seq_rd_addr), 32'd0);
            cur_idx = 0;
            return;
         end
      end
      cur_idx = new_idx;
   endtask

   initial begin
      for (int i = 0; i < 32; i++) mem[i] = 2'($urandom_range(0, 3));

      // Reset state
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      chk_idle("reset", 0);
      chk("reset.addr", 32'(seq_rd_addr), 32'd0);

      // Directed three-step sequence: blue, red, yellow
      mem[0] = COL_BLUE;
      mem[1] = COL_RED;
      mem[2] = COL_YELLOW;
      run("len3", 3, 10, -1, -1, 1'b0, -1);

      // Zero-length request completes without lighting anything
      run("len0", 0, 10, -1, -1, 1'b0, -1);

      // Over-long request clamps to the full RAM depth
      for (int i = 0; i < 32; i++) mem[i] = 2'($urandom_range(0, 3));
      run("len40", 40, 3, -1, -1, 1'b0, -1);

      // Stale pulses and a start while busy must be ignored
      run("filter", 3, 10, -1, -1, 1'b1, 10);

      // Abort in the gap of step 1, then a fresh playback from step 0
      run("abort", 3, 10, 39, -1, 1'b0, -1);
      run("replay", 3, 4, -1, -1, 1'b0, -1);

      // Reset while a LED is lit
      run("midreset", 5, 6, -1, 5, 1'b0, -1);

      // Randomized playbacks
      for (int r = 0; r < 6; r++) begin
         for (int i = 0; i < 32; i++) mem[i] = 2'($urandom_range(0, 3));
         run($sformatf("rnd%0d", r), int'($urandom_range(1, 8)),
             int'($urandom_range(1, 6)), -1, -1, 1'($urandom_range(0, 1)), -1);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
